// File: rtl/drum_step_sequencer.sv
// drum_step_sequencer
// Keypad-driven drum step sequencer: turns key presses into commands, plays an
// NSTEPS x NVOICE pattern on a tempo counter and emits one-cycle voice triggers.
// Optional metronome output is built only when DRUM_SEQ_METRO_EN is defined;
// otherwise metro is tied low and no metronome logic exists.
module drum_step_sequencer #(
    parameter int NSTEPS    = 16,
    parameter int NVOICE    = 4,
    parameter int BASE_DIV  = 1_000_000,
    parameter int TEMPO_RST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4:0]                keycode,
    input  logic                      strobe,
    output logic [NVOICE-1:0]         voice_trig,
    output logic [$clog2(NSTEPS)-1:0] step_idx,
    output logic                      playing,
    output logic                      recording,
    output logic [2:0]                tempo,
    output logic                      metro
);

    localparam int SW    = $clog2(NSTEPS);
    // Counter must hold up to the longest period minus one (tempo 0 -> 8*BASE_DIV).
    localparam int CNT_W = $clog2(BASE_DIV * 8);

    localparam logic [CNT_W:0] BASE_PERIOD = (CNT_W+1)'(BASE_DIV);
    localparam logic [CNT_W:0] ONE_CNT     = (CNT_W+1)'(1);
    localparam logic [4:0]     NV_KEYS     = 5'(NVOICE);

    localparam logic [4:0] KEY_CLEAR = 5'd15;
    localparam logic [4:0] KEY_PLAY  = 5'd16;
    localparam logic [4:0] KEY_REC   = 5'd17;
    localparam logic [4:0] KEY_UP    = 5'd18;
    localparam logic [4:0] KEY_DOWN  = 5'd19;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_REC  = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic                strobe_q_reg;
    logic [SW-1:0]       step_reg, step_next;
    logic [CNT_W-1:0]    count_reg, count_next;
    logic [2:0]          tempo_reg, tempo_next;
    logic [NVOICE-1:0]   trig_reg, trig_next;
    logic [NVOICE-1:0]   pattern_reg  [NSTEPS];
    logic [NVOICE-1:0]   pattern_next [NSTEPS];

    logic                evt;
    logic                is_voice;
    logic [NVOICE-1:0]   voice_onehot;
    logic                running;
    logic [CNT_W:0]      period;
    logic                terminal;
    logic                start;
    logic                step_trig_en;
    logic                clear_all;
    logic                rec_write;

    // A held key produces exactly one event: the rising edge of strobe.
    assign evt      = strobe & ~strobe_q_reg;
    assign is_voice = evt && (keycode < NV_KEYS);
    assign running  = (state_reg != ST_IDLE);

    // One-hot voice select for audition triggers and recording writes.
    generate
        for (genvar gi = 0; gi < NVOICE; gi++) begin : g_onehot
            assign voice_onehot[gi] = is_voice && (keycode == 5'(gi));
        end
    endgenerate

    // Step period in clocks; terminal uses >= so a shortened period ends the step at once.
    assign period   = BASE_PERIOD * (CNT_W+1)'(4'd8 - {1'b0, tempo_reg});
    assign terminal = running && ({1'b0, count_reg} >= (period - ONE_CNT));

    // Clear is only honoured while stopped; voice keys only write while recording.
    assign clear_all = evt && (state_reg == ST_IDLE) && (keycode == KEY_CLEAR);
    assign rec_write = (state_reg == ST_REC);

    // Per-step pattern update: whole-pattern clear or OR-in of the recorded voice.
    generate
        for (genvar gi = 0; gi < NSTEPS; gi++) begin : g_pattern
            assign pattern_next[gi] = clear_all ? '0 :
                                      (rec_write && (step_reg == SW'(gi))) ?
                                          (pattern_reg[gi] | voice_onehot) :
                                          pattern_reg[gi];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic driven by play/stop and record keys.
    always_comb begin
        state_next = state_reg;
        if (evt) begin
            case (state_reg)
                ST_IDLE: begin
                    if (keycode == KEY_PLAY) begin
                        state_next = ST_PLAY;
                    end else if (keycode == KEY_REC) begin
                        state_next = ST_REC;
                    end
                end
                ST_PLAY: begin
                    if (keycode == KEY_PLAY) begin
                        state_next = ST_IDLE;
                    end else if (keycode == KEY_REC) begin
                        state_next = ST_REC;
                    end
                end
                ST_REC: begin
                    if (keycode == KEY_PLAY) begin
                        state_next = ST_IDLE;
                    end else if (keycode == KEY_REC) begin
                        state_next = ST_PLAY;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Step/counter control: a state change in the same cycle as a terminal count
    // takes priority, so the step neither advances nor triggers on that edge.
    always_comb begin
        step_next    = step_reg;
        count_next   = count_reg;
        step_trig_en = 1'b0;
        start        = (state_reg == ST_IDLE) && (state_next != ST_IDLE);
        if (state_next == ST_IDLE) begin
            step_next  = '0;
            count_next = '0;
        end else if (start) begin
            step_next    = '0;
            count_next   = '0;
            step_trig_en = 1'b1;
        end else if (state_next != state_reg) begin
            step_next  = step_reg;
            count_next = count_reg;
        end else if (terminal) begin
            step_next    = step_reg + SW'(1);
            count_next   = '0;
            step_trig_en = 1'b1;
        end else begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    // Trigger word: new step's pattern OR'd with any audition voice.
    always_comb begin
        trig_next = voice_onehot;
        if (step_trig_en) begin
            trig_next = trig_next | pattern_reg[step_next];
        end
    end

    // Saturating tempo adjust, allowed in every state.
    always_comb begin
        tempo_next = tempo_reg;
        if (evt && (keycode == KEY_UP) && (tempo_reg != 3'd7)) begin
            tempo_next = tempo_reg + 3'd1;
        end else if (evt && (keycode == KEY_DOWN) && (tempo_reg != 3'd0)) begin
            tempo_next = tempo_reg - 3'd1;
        end
    end

    // Datapath registers: strobe history, step, counter, tempo, trigger output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            strobe_q_reg <= 1'b0;
            step_reg     <= '0;
            count_reg    <= '0;
            tempo_reg    <= 3'(TEMPO_RST);
            trig_reg     <= '0;
        end else begin
            strobe_q_reg <= strobe;
            step_reg     <= step_next;
            count_reg    <= count_next;
            tempo_reg    <= tempo_next;
            trig_reg     <= trig_next;
        end
    end

    // Pattern storage; cleared by reset so a reset mid-play loses the pattern.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NSTEPS; i++) begin
                pattern_reg[i] <= '0;
            end
        end else begin
            pattern_reg <= pattern_next;
        end
    end

`ifdef DRUM_SEQ_METRO_EN
    logic metro_reg;

    // Metronome click aligned with step triggers landing on multiples of 4.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            metro_reg <= 1'b0;
        end else begin
            metro_reg <= step_trig_en && (step_next[1:0] == 2'b00);
        end
    end

    assign metro = metro_reg;
`else
    assign metro = 1'b0;
`endif

    assign voice_trig = trig_reg;
    assign step_idx   = step_reg;
    assign playing    = running;
    assign recording  = (state_reg == ST_REC);
    assign tempo      = tempo_reg;

endmodule
